// File: rtl/tug_playfield_if.sv
`default_nettype none
// ============================================================================
// Module      : tug_playfield_if
// Description : Press-pulse inputs and display outputs of the tug-of-war
//               playfield, with master (driver) and slave (playfield) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface tug_playfield_if #(
  parameter int NUM_POS = 9,
  parameter int SCORE_W = 3
);
  logic               left_pulse;
  logic               right_pulse;
  logic [NUM_POS-1:0] leds;
  logic [SCORE_W-1:0] left_score;
  logic [SCORE_W-1:0] right_score;
  logic [1:0]         winner;
  logic               round_over;
  logic               match_over;

  modport master (
    output left_pulse, right_pulse,
    input  leds, left_score, right_score, winner, round_over, match_over
  );

  modport slave (
    input  left_pulse, right_pulse,
    output leds, left_score, right_score, winner, round_over, match_over
  );
endinterface
`default_nettype wire

// File: rtl/tug_playfield.sv
`default_nettype none
// ============================================================================
// Module      : tug_playfield
// Description : Rope position, round/match detection and scoring for the
//               tug-of-war game. Optional macro TUG_LOCKOUT_EN adds a press
//               lockout window at the start of every PLAY entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tug_playfield #(
  parameter int NUM_POS        = 9,
  parameter int SCORE_W        = 3,
  parameter int MAX_SCORE      = 7,
  parameter int HOLD_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  tug_playfield_if.slave     bus
);

  localparam int PW = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PW-1:0]      C_CENTRE    = PW'(NUM_POS / 2);
  localparam logic [PW-1:0]      C_LAST      = PW'(NUM_POS - 1);
  localparam logic [HW-1:0]      C_HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] C_MAX       = SCORE_W'(MAX_SCORE);
  localparam logic [NUM_POS-1:0] C_ONE       = NUM_POS'(1);

  typedef enum logic [1:0] {
    ST_PLAY       = 2'd0,
    ST_ROUND_WON  = 2'd1,
    ST_MATCH_OVER = 2'd2
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [PW-1:0]      r_pos,         w_pos_nxt;
  logic [NUM_POS-1:0] r_leds;
  logic [SCORE_W-1:0] r_left_score,  w_left_score_nxt;
  logic [SCORE_W-1:0] r_right_score, w_right_score_nxt;
  logic [1:0]         r_winner,      w_winner_nxt;
  logic [HW-1:0]      r_hold,        w_hold_nxt;
  logic               r_round_over;
  logic               r_match_over;
  logic               w_accept;
  logic               w_recentre;

  logic [SCORE_W-1:0] w_left_inc;
  logic [SCORE_W-1:0] w_right_inc;

  assign w_left_inc  = r_left_score + 1'b1;
  assign w_right_inc = r_right_score + 1'b1;
  assign w_recentre  = (r_state == ST_ROUND_WON) && (r_hold == '0);

`ifdef TUG_LOCKOUT_EN
  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [LW-1:0] C_LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  logic [LW-1:0] r_lock;

  // Counts down through the first PLAY cycles; presses count once it hits 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock <= C_LOCK_LOAD;
    end else if (w_recentre) begin
      r_lock <= C_LOCK_LOAD;
    end else if ((r_state == ST_PLAY) && (r_lock != '0)) begin
      r_lock <= r_lock - 1'b1;
    end
  end

  assign w_accept = (r_lock == '0);
`else
  logic w_unused_lockout;
  assign w_unused_lockout = (LOCKOUT_CYCLES != 0);
  assign w_accept         = 1'b1;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_pos_nxt         = r_pos;
    w_left_score_nxt  = r_left_score;
    w_right_score_nxt = r_right_score;
    w_winner_nxt      = r_winner;
    w_hold_nxt        = r_hold;
    case (r_state)
      ST_PLAY: begin
        if (w_accept && bus.left_pulse && !bus.right_pulse) begin
          if (r_pos == C_LAST) begin
            w_left_score_nxt = w_left_inc;
            w_winner_nxt     = 2'b10;
            w_hold_nxt       = C_HOLD_LOAD;
            w_state_nxt      = (w_left_inc == C_MAX) ? ST_MATCH_OVER : ST_ROUND_WON;
          end else begin
            w_pos_nxt = r_pos + 1'b1;
          end
        end else if (w_accept && bus.right_pulse && !bus.left_pulse) begin
          if (r_pos == '0) begin
            w_right_score_nxt = w_right_inc;
            w_winner_nxt      = 2'b01;
            w_hold_nxt        = C_HOLD_LOAD;
            w_state_nxt       = (w_right_inc == C_MAX) ? ST_MATCH_OVER : ST_ROUND_WON;
          end else begin
            w_pos_nxt = r_pos - 1'b1;
          end
        end
      end
      ST_ROUND_WON: begin
        if (w_recentre) begin
          w_state_nxt = ST_PLAY;
          w_pos_nxt   = C_CENTRE;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      ST_MATCH_OVER: begin
        w_state_nxt = ST_MATCH_OVER;
      end
      default: begin
        w_state_nxt = ST_PLAY;
        w_pos_nxt   = C_CENTRE;
      end
    endcase
  end

  // leds and status flags are registered from next-state so they line up with pos.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_PLAY;
      r_pos         <= C_CENTRE;
      r_leds        <= C_ONE << (NUM_POS / 2);
      r_left_score  <= '0;
      r_right_score <= '0;
      r_winner      <= 2'b00;
      r_hold        <= '0;
      r_round_over  <= 1'b0;
      r_match_over  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pos         <= w_pos_nxt;
      r_leds        <= C_ONE << w_pos_nxt;
      r_left_score  <= w_left_score_nxt;
      r_right_score <= w_right_score_nxt;
      r_winner      <= w_winner_nxt;
      r_hold        <= w_hold_nxt;
      r_round_over  <= (w_state_nxt == ST_ROUND_WON);
      r_match_over  <= (w_state_nxt == ST_MATCH_OVER);
    end
  end

  assign bus.leds        = r_leds;
  assign bus.left_score  = r_left_score;
  assign bus.right_score = r_right_score;
  assign bus.winner      = r_winner;
  assign bus.round_over  = r_round_over;
  assign bus.match_over  = r_match_over;

endmodule
`default_nettype wire

// File: tb/tb_tug_playfield.sv
`default_nettype none
// ============================================================================
// Module      : tb_tug_playfield
// Description : Directed self-checking bench for tug_playfield (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tug_playfield;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  tug_playfield_if #(.NUM_POS(9), .SCORE_W(3)) bus ();

  tug_playfield #(
    .NUM_POS        (9),
    .SCORE_W        (3),
    .MAX_SCORE      (7),
    .HOLD_CYCLES    (16),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of pulses; returns 1 ns after the capturing edge.
  task automatic step(input logic l, input logic r);
    @(negedge clock);
    bus.left_pulse  = l;
    bus.right_pulse = r;
    @(posedge clock);
    #1;
    bus.left_pulse  = 1'b0;
    bus.right_pulse = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_leds"},   bus.leds,        32'h010);
    check({tag, "_lscore"}, bus.left_score,  32'd0);
    check({tag, "_rscore"}, bus.right_score, 32'd0);
    check({tag, "_winner"}, bus.winner,      32'd0);
    check({tag, "_rover"},  bus.round_over,  32'd0);
    check({tag, "_mover"},  bus.match_over,  32'd0);
  endtask

  initial begin
    logic [8:0] walk [4];
    walk[0] = 9'b000100000;
    walk[1] = 9'b001000000;
    walk[2] = 9'b010000000;
    walk[3] = 9'b100000000;
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    bus.left_pulse  = 1'b0;
    bus.right_pulse = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("rst");
    @(negedge clock);
    reset = 1'b0;

    // Walk left to the edge
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("walk%0d_leds", i), bus.leds, 32'(walk[i]));
    end
    check("walk_lscore", bus.left_score, 32'd0);

    // Left wins the round from the edge
    step(1'b1, 1'b0);
    check("lwin_lscore", bus.left_score, 32'd1);
    check("lwin_winner", bus.winner,     32'h2);
    check("lwin_rover",  bus.round_over, 32'd1);
    check("lwin_leds",   bus.leds,       32'h100);

    // Right pulses during the hold are ignored
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    check("hold_leds",   bus.leds,        32'h100);
    check("hold_rscore", bus.right_score, 32'd0);
    check("hold_lscore", bus.left_score,  32'd1);
    idle(12);
    check("hold_last_rover", bus.round_over, 32'd1);
    step(1'b0, 1'b0);
    check("recentre_rover",  bus.round_over, 32'd0);
    check("recentre_leds",   bus.leds,       32'h010);
    check("recentre_winner", bus.winner,     32'h2);

    // Simultaneous presses cancel
    step(1'b1, 1'b1);
    check("both_leds",   bus.leds,        32'h010);
    check("both_lscore", bus.left_score,  32'd1);
    check("both_rscore", bus.right_score, 32'd0);

    // Right player takes seven rounds and the match
    for (int r = 1; r <= 7; r++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      check($sformatf("rround%0d_rscore", r), bus.right_score, 32'(r));
      check($sformatf("rround%0d_leds", r),   bus.leds,        32'h001);
      if (r < 7) begin
        check($sformatf("rround%0d_rover", r), bus.round_over, 32'd1);
        idle(16);
        check($sformatf("rround%0d_centre", r), bus.leds, 32'h010);
      end
    end
    check("match_mover",  bus.match_over, 32'd1);
    check("match_rover",  bus.round_over, 32'd0);
    check("match_winner", bus.winner,     32'h1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(20);
    check("frozen_leds",   bus.leds,        32'h001);
    check("frozen_rscore", bus.right_score, 32'd7);
    check("frozen_lscore", bus.left_score,  32'd1);
    check("frozen_mover",  bus.match_over,  32'd1);

    // Fresh match: left to 3, then asynchronous reset mid-hold
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      if (r < 3) idle(16);
    end
    check("pre_async_lscore", bus.left_score, 32'd3);
    idle(3);
    check("pre_async_rover", bus.round_over, 32'd1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b1);
    check("post_async_leds",  bus.leds,       32'h008);
    check("post_async_rover", bus.round_over, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
